round_sequencer: RTL and testbench

Game-round controller between the collision detector and the movers (raccoon and car controllers). It sequences the game from idle through running, hit-freeze, level-up pause, win and game-over. It owns the lives count, the current level and the per-level car speed, and issues freeze and respawn commands to the raccoon and car controllers.

---
 rtl/round_sequencer_if.sv | 50 +++++
 rtl/round_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_round_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/round_sequencer_if.sv
// ----------------------------------------------------------------------------
// round_sequencer_if
// Signal bundle between the round sequencer and its neighbours.
//   i_Start      start request level (all three buttons held)
//   i_Collision  raccoon/car overlap level
//   i_Goal       raccoon on the goal row level
//   o_Game_State 00 idle, 01 running, 10 win, 11 game over
//   o_Freeze     movers hold position while high
//   o_Respawn    one-cycle pulse returning the raccoon to its start
//   o_Lives      remaining lives
//   o_Level      current level
//   o_Car_Speed  car step size
// slave  : the sequencer side (takes requests, drives status)
// master : the game/testbench side (drives requests, reads status)
// ----------------------------------------------------------------------------
interface round_sequencer_if;
   logic       i_Start;
   logic       i_Collision;
   logic       i_Goal;
   logic [1:0] o_Game_State;
   logic       o_Freeze;
   logic       o_Respawn;
   logic [2:0] o_Lives;
   logic [3:0] o_Level;
   logic [2:0] o_Car_Speed;

   modport slave (
      input  i_Start,
      input  i_Collision,
      input  i_Goal,
      output o_Game_State,
      output o_Freeze,
      output o_Respawn,
      output o_Lives,
      output o_Level,
      output o_Car_Speed
   );

   modport master (
      output i_Start,
      output i_Collision,
      output i_Goal,
      input  o_Game_State,
      input  o_Freeze,
      input  o_Respawn,
      input  o_Lives,
      input  o_Level,
      input  o_Car_Speed
   );
endinterface

// File: rtl/round_sequencer.sv
// ----------------------------------------------------------------------------
// round_sequencer
// Game-round controller: sequences idle -> run -> hit freeze / level-up pause
// -> win / game over, owns lives, level and car speed, and issues freeze and
// respawn commands to the raccoon and car controllers.
//
// Ports:
//   i_Clk    system clock
//   i_Reset  synchronous, active-high reset
//   bus      round_sequencer_if.slave (start/collision/goal in, status out)
//
// Parameters:
//   P_LIVES         starting lives (1-7)
//   P_MAX_LEVEL     level value that means win (1-15)
//   P_HIT_CYCLES    freeze length after a hit
//   P_LVL_CYCLES    pause length after reaching the goal
//   P_GRACE_CYCLES  post-respawn invulnerability window
//
// Build option:
//   ROUND_SEQ_GRACE_EN  when defined, collisions are ignored for
//                       P_GRACE_CYCLES RUN cycles after every respawn.
// ----------------------------------------------------------------------------
module round_sequencer #(
   parameter int unsigned P_LIVES        = 3,
   parameter int unsigned P_MAX_LEVEL    = 9,
   parameter int unsigned P_HIT_CYCLES   = 25_000_000,
   parameter int unsigned P_LVL_CYCLES   = 12_500_000,
   parameter int unsigned P_GRACE_CYCLES = 12_500_000
) (
   input  logic              i_Clk,
   input  logic              i_Reset,
   round_sequencer_if.slave  bus
);

   // Timer is sized from the largest cycle parameter so it can hold any load.
   localparam int unsigned MAX_HL  = (P_HIT_CYCLES > P_LVL_CYCLES) ? P_HIT_CYCLES : P_LVL_CYCLES;
   localparam int unsigned MAX_CYC = (MAX_HL > P_GRACE_CYCLES) ? MAX_HL : P_GRACE_CYCLES;
   localparam int unsigned TMR_W   = ($clog2(MAX_CYC) > 0) ? $clog2(MAX_CYC) : 1;
   localparam int unsigned LIVES_W = 3;
   localparam int unsigned LEVEL_W = 4;
   localparam int unsigned SPEED_W = 3;

   localparam logic [TMR_W-1:0]   HIT_LOAD   = TMR_W'(P_HIT_CYCLES - 1);
   localparam logic [TMR_W-1:0]   LVL_LOAD   = TMR_W'(P_LVL_CYCLES - 1);
   localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(P_LIVES);
   localparam logic [LEVEL_W-1:0] LEVEL_WIN  = LEVEL_W'(P_MAX_LEVEL);

   // FSM encoding
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RUN   = 3'd1;
   localparam logic [2:0] ST_HIT   = 3'd2;
   localparam logic [2:0] ST_LVLUP = 3'd3;
   localparam logic [2:0] ST_WIN   = 3'd4;
   localparam logic [2:0] ST_OVER  = 3'd5;

   localparam logic [1:0] GS_IDLE = 2'b00;
   localparam logic [1:0] GS_RUN  = 2'b01;
   localparam logic [1:0] GS_WIN  = 2'b10;
   localparam logic [1:0] GS_OVER = 2'b11;

   logic [2:0]         state_q, state_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic [SPEED_W-1:0] speed_q, speed_d;
   logic [1:0]         game_state_q, game_state_d;
   logic               freeze_q, freeze_d;
   logic               respawn_q, respawn_d;
   logic               start_low_q, start_low_d;

   logic               start_rise_c;
   logic               hit_c;
   logic [LEVEL_W-1:0] level_inc_c;

   // start_low_q is only set after i_Start was seen low, so a button held
   // through reset cannot produce a rising edge.
   assign start_rise_c = bus.i_Start & start_low_q;
   assign start_low_d  = ~bus.i_Start;
   assign level_inc_c  = level_q + LEVEL_W'(1);

`ifdef ROUND_SEQ_GRACE_EN
   localparam int unsigned GR_W = ($clog2(P_GRACE_CYCLES + 1) > 0) ? $clog2(P_GRACE_CYCLES + 1) : 1;
   localparam logic [GR_W-1:0] GRACE_LOAD = GR_W'(P_GRACE_CYCLES);

   logic [GR_W-1:0] grace_q, grace_d;

   // Collisions only count once the post-respawn window has expired.
   assign hit_c = bus.i_Collision & (grace_q == '0);

   // Grace window: load on respawn, count down while running, clear otherwise.
   always_comb begin
      grace_d = '0;
      if (respawn_d) begin
         grace_d = GRACE_LOAD;
      end else if ((state_q == ST_RUN) && (state_d == ST_RUN) && (grace_q != '0)) begin
         grace_d = grace_q - GR_W'(1);
      end
   end

   // Grace counter register
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         grace_q <= '0;
      end else begin
         grace_q <= grace_d;
      end
   end
`else
   assign hit_c = bus.i_Collision;
`endif

   // Next-state and next-output logic
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      lives_d      = lives_q;
      level_d      = level_q;
      respawn_d    = 1'b0;
      freeze_d     = 1'b1;
      game_state_d = GS_IDLE;

      case (state_q)
         ST_IDLE: begin
            lives_d = LIVES_INIT;
            level_d = '0;
            if (start_rise_c) begin
               state_d   = ST_RUN;
               respawn_d = 1'b1;
            end
         end

         ST_RUN: begin
            // Collision wins over goal in the same cycle.
            if (hit_c) begin
               state_d = ST_HIT;
               lives_d = (lives_q == '0) ? '0 : (lives_q - LIVES_W'(1));
               timer_d = HIT_LOAD;
            end else if (bus.i_Goal) begin
               level_d = level_inc_c;
               if (level_inc_c == LEVEL_WIN) begin
                  state_d = ST_WIN;
               end else begin
                  state_d = ST_LVLUP;
                  timer_d = LVL_LOAD;
               end
            end
         end

         ST_HIT: begin
            if (timer_q == '0) begin
               if (lives_q == '0) begin
                  state_d = ST_OVER;
               end else begin
                  state_d   = ST_RUN;
                  respawn_d = 1'b1;
               end
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end

         ST_LVLUP: begin
            if (timer_q == '0) begin
               state_d   = ST_RUN;
               respawn_d = 1'b1;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end

         ST_WIN, ST_OVER: begin
            if (start_rise_c) begin
               state_d = ST_IDLE;
               lives_d = LIVES_INIT;
               level_d = '0;
            end
         end

         default: begin
            state_d = ST_IDLE;
            timer_d = '0;
         end
      endcase

      // Status outputs are decoded from the next state so they register
      // alongside it.
      freeze_d = (state_d != ST_RUN);
      case (state_d)
         ST_RUN, ST_HIT, ST_LVLUP: game_state_d = GS_RUN;
         ST_WIN:                   game_state_d = GS_WIN;
         ST_OVER:                  game_state_d = GS_OVER;
         default:                  game_state_d = GS_IDLE;
      endcase
   end

   // Speed follows the registered level one cycle later.
   assign speed_d = SPEED_W'(1) + SPEED_W'(level_q >> 1);

   // State and output registers
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         lives_q      <= LIVES_INIT;
         level_q      <= '0;
         speed_q      <= SPEED_W'(1);
         game_state_q <= GS_IDLE;
         freeze_q     <= 1'b1;
         respawn_q    <= 1'b0;
         start_low_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         lives_q      <= lives_d;
         level_q      <= level_d;
         speed_q      <= speed_d;
         game_state_q <= game_state_d;
         freeze_q     <= freeze_d;
         respawn_q    <= respawn_d;
         start_low_q  <= start_low_d;
      end
   end

   assign bus.o_Game_State = game_state_q;
   assign bus.o_Freeze     = freeze_q;
   assign bus.o_Respawn    = respawn_q;
   assign bus.o_Lives      = lives_q;
   assign bus.o_Level      = level_q;
   assign bus.o_Car_Speed  = speed_q;

endmodule

// File: tb/tb_round_sequencer.sv
// ----------------------------------------------------------------------------
// tb_round_sequencer
// Self-checking bench for round_sequencer: directed scenarios for reset,
// start, hits, game over, level-up, win, simultaneous events, mid-timer reset
// and the grace window, then a randomized run. A behavioural game model tracks
// the expected outputs and is compared every cycle.
// ----------------------------------------------------------------------------
module tb_round_sequencer;

   localparam int unsigned L_LIVES = 3;
   localparam int unsigned L_MAXL  = 2;
   localparam int unsigned L_HIT   = 4;
   localparam int unsigned L_LVL   = 3;
   localparam int unsigned L_GRACE = 5;
`ifdef ROUND_SEQ_GRACE_EN
   localparam int GRACE_EFF = L_GRACE;
`else
   localparam int GRACE_EFF = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   round_sequencer_if bus ();

   round_sequencer #(
      .P_LIVES        (L_LIVES),
      .P_MAX_LEVEL    (L_MAXL),
      .P_HIT_CYCLES   (L_HIT),
      .P_LVL_CYCLES   (L_LVL),
      .P_GRACE_CYCLES (L_GRACE)
   ) dut (
      .i_Clk   (clk),
      .i_Reset (rst),
      .bus     (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Behavioural game model
   typedef enum int {M_IDLE, M_RUN, M_HIT, M_LVL, M_WIN, M_OVER} phase_t;
   phase_t ph = M_IDLE;
   int m_lives = 0, m_level = 0, m_speed = 0, hold = 0, grace = 0;
   bit m_respawn = 0, armed = 0, m_valid = 0;

   function automatic logic [1:0] gs_of(input phase_t p);
      case (p)
         M_IDLE:  return 2'b00;
         M_WIN:   return 2'b10;
         M_OVER:  return 2'b11;
         default: return 2'b01;
      endcase
   endfunction

   always @(posedge clk) begin : model
      int  new_speed;
      bit  rise;
      bit  hit;
      new_speed = 1 + m_level / 2;
      rise      = bus.i_Start && armed;
      armed     = !bus.i_Start;
      m_respawn = 0;
      if (rst) begin
         ph = M_IDLE; m_lives = L_LIVES; m_level = 0; m_speed = 1;
         hold = 0; grace = 0; armed = 0; m_valid = 1;
      end else begin
         m_speed = new_speed;
         case (ph)
            M_IDLE: begin
               m_lives = L_LIVES; m_level = 0;
               if (rise) begin ph = M_RUN; m_respawn = 1; grace = GRACE_EFF; end
            end
            M_RUN: begin
               hit = bus.i_Collision && (grace == 0);
               if (grace > 0) grace = grace - 1;
               if (hit) begin
                  m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                  ph = M_HIT; hold = L_HIT; grace = 0;
               end else if (bus.i_Goal) begin
                  m_level = m_level + 1;
                  grace = 0;
                  if (m_level == L_MAXL) ph = M_WIN;
                  else begin ph = M_LVL; hold = L_LVL; end
               end
            end
            M_HIT, M_LVL: begin
               hold = hold - 1;
               if (hold == 0) begin
                  if (ph == M_HIT && m_lives == 0) ph = M_OVER;
                  else begin ph = M_RUN; m_respawn = 1; grace = GRACE_EFF; end
               end
            end
            default: begin
               if (rise) begin ph = M_IDLE; m_lives = L_LIVES; m_level = 0; end
            end
         endcase
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin : compare
      logic [13:0] act, exp;
      if (m_valid) begin
         act = {bus.o_Game_State, bus.o_Freeze, bus.o_Respawn, bus.o_Lives,
                bus.o_Level, bus.o_Car_Speed};
         exp = {gs_of(ph), (ph != M_RUN), m_respawn, 3'(m_lives), 4'(m_level), 3'(m_speed)};
         checks = checks + 1;
         if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL model_cmp t=%0t actual gs/frz/rsp/lives/lvl/spd=%b/%b/%b/%0d/%0d/%0d required=%b/%b/%b/%0d/%0d/%0d",
                     $time, act[13:12], act[11], act[10], act[9:7], act[6:3], act[2:0],
                     exp[13:12], exp[11], exp[10], exp[9:7], exp[6:3], exp[2:0]);
         end
      end
   end

   task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // One clock: apply inputs, let a posedge pass, return at the next negedge.
   task automatic step(input logic r, input logic s, input logic c, input logic g);
      rst = r; bus.i_Start = s; bus.i_Collision = c; bus.i_Goal = g;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic start_game();
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   // Hit after the grace window (if any) has expired, then ride out the freeze.
   task automatic do_hit();
      idle(L_GRACE);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      idle(L_HIT);
   endtask

   initial begin
      int n;
      bus.i_Start = 1'b0; bus.i_Collision = 1'b0; bus.i_Goal = 1'b0;

      // Reset with start held: must stay idle
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check_lit("reset_state", 32'(bus.o_Game_State), 0);
      check_lit("reset_lives", 32'(bus.o_Lives), 3);
      check_lit("reset_speed", 32'(bus.o_Car_Speed), 1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check_lit("held_start_idle", 32'(bus.o_Game_State), 0);

      // Proper start edge
      start_game();
      check_lit("start_state", 32'(bus.o_Game_State), 1);
      check_lit("start_respawn", 32'(bus.o_Respawn), 1);
      check_lit("start_freeze", 32'(bus.o_Freeze), 0);

      // First hit: lives 3 -> 2, four frozen cycles, then respawn
      idle(L_GRACE);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check_lit("hit_lives", 32'(bus.o_Lives), 2);
      check_lit("hit_freeze", 32'(bus.o_Freeze), 1);
      idle(L_HIT - 1);
      check_lit("hit_freeze_last", 32'(bus.o_Freeze), 1);
      idle(1);
      check_lit("hit_respawn", 32'(bus.o_Respawn), 1);
      check_lit("hit_back_run", 32'(bus.o_Freeze), 0);

      // Two more hits: game over without respawn
      do_hit();
      do_hit();
      check_lit("over_state", 32'(bus.o_Game_State), 3);
      check_lit("over_lives", 32'(bus.o_Lives), 0);
      check_lit("over_no_respawn", 32'(bus.o_Respawn), 0);
      start_game();
      check_lit("over_to_idle", 32'(bus.o_Game_State), 0);
      check_lit("idle_lives", 32'(bus.o_Lives), 3);

      // Level up then win
      start_game();
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check_lit("lvl1_level", 32'(bus.o_Level), 1);
      check_lit("lvl1_freeze", 32'(bus.o_Freeze), 1);
      idle(1);
      check_lit("lvl1_speed", 32'(bus.o_Car_Speed), 1);
      idle(L_LVL - 1);
      check_lit("lvl1_respawn", 32'(bus.o_Respawn), 1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check_lit("win_state", 32'(bus.o_Game_State), 2);
      check_lit("win_level", 32'(bus.o_Level), 2);
      idle(1);
      check_lit("win_speed", 32'(bus.o_Car_Speed), 2);
      start_game();
      check_lit("win_to_idle_level", 32'(bus.o_Level), 0);

      // Collision and goal together, then reset mid-freeze
      start_game();
      idle(L_GRACE);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check_lit("both_level", 32'(bus.o_Level), 0);
      check_lit("both_lives", 32'(bus.o_Lives), 2);
      idle(1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check_lit("midrst_state", 32'(bus.o_Game_State), 0);
      check_lit("midrst_lives", 32'(bus.o_Lives), 3);
      check_lit("midrst_freeze", 32'(bus.o_Freeze), 1);

      // Collision held through start: count RUN cycles until the hit lands
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check_lit("grace_start", 32'(bus.o_Respawn), 1);
      n = 0;
      while (n < 20 && bus.o_Freeze !== 1'b1) begin
         step(1'b0, 1'b0, 1'b1, 1'b0);
         n = n + 1;
      end
      check_lit("grace_cycles", 32'(n), 32'(GRACE_EFF + 1));

      // Randomized play
      step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
